serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing `a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's parallel ripple-carry adder, for area-constrained datapaths that can trade latency for gates. A start/busy/done handshake frames each operation. Results are held stable until the next accepted start.

---
 rtl/serial_subtractor.sv | 81 ++++++++
 tb/tb_serial_subtractor.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow flop
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request an operation, sampled only while idle
//   a, b  : minuend / subtrahend, captured on the accepting edge
//   bin   : borrow-in, captured on the accepting edge
//   busy  : operation in progress
//   done  : one-cycle pulse marking a fresh diff/bout
//   diff  : (a - b - bin) mod 2^WIDTH, held until the next completion
//   bout  : borrow-out, 1 when a < b + bin
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, r_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, busy_q, done_q, bout_q;
    logic             d, br_d;
    logic [WIDTH-1:0] r_d;
    assign d    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    // Result fills from the MSB down, so after WIDTH shifts bit 0 lands at index 0.
    assign r_d  = {d, r_q[WIDTH-1:1]};
    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    br_q    <= bin;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= BUSY;
                end
            end else begin
                a_q  <= a_q >> 1;
                b_q  <= b_q >> 1;
                r_q  <= r_d;
                br_q <= br_d;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_q  <= r_d;
                    bout_q  <= br_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor with WIDTH=4
module tb_serial_subtractor;
    localparam int W = 4;
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, bout;
    logic [W-1:0] diff;
    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        int           c0;
    } exp_t;
    exp_t         sb[$];
    int           pass_n = 0, total_n = 0, cyc = 0;
    logic [W-1:0] hold_diff = '0;
    logic         hold_bout = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: compares every done against the oldest expectation and checks holds between.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_done_exclusive", int'(busy && done), 0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("diff", diff, e.diff);
                    chk("bout", bout, e.bout);
                    chk("latency", cyc - e.c0, W);
                end
                hold_diff = diff;
                hold_bout = bout;
            end else begin
                chk("diff_hold", diff, hold_diff);
                chk("bout_hold", bout, hold_bout);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    // Drives a request that must be accepted on the next edge and queues its result.
    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                      input logic [W-1:0] ed, input logic eb);
        exp_t e;
        wait_idle();
        a = av; b = bv; bin = bi; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        e.diff = ed; e.bout = eb; e.c0 = cyc;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        int n;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
        op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
        op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
        op(4'd7, 4'd7, 1'b0, 4'h0, 1'b0);
        op(4'hF, 4'd0, 1'b1, 4'hE, 1'b0);

        // A start raised mid-operation must be ignored.
        op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Back-to-back: start held high from mid-op through the done cycle.
        op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
        @(negedge clk);
        a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_done", done, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_accept", busy, 1);
        e.diff = 4'd3; e.bout = 1'b0; e.c0 = cyc;
        sb.push_back(e);

        // Asynchronous reset mid-operation.
        op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_diff", diff, 0);
        chk("arst_bout", bout, 0);
        sb.delete();
        hold_diff = '0;
        hold_bout = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        chk("no_done_after_abort", done, 0);

        op(4'd2, 4'd1, 1'b0, 4'd1, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
